// File: rtl/sample_burst_writer_pkg.sv
// Shared types and constants for sample_burst_writer: burst sequencer states,
// fixed AXI4 encodings and the FIFO level width helper.
package sample_burst_writer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // A level counter must represent 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sample_burst_writer_if.sv
// AXI4 write-only channel bundle (AW, W, B) between the burst writer and
// the sampler memory slave.
interface sample_burst_writer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awid;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awid, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awid, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    output awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/sample_fifo.sv
// First-word-fall-through sample FIFO. The head entry is visible on `head`
// whenever `empty` is low; level, full and empty come from registered state.
module sample_fifo
  import sample_burst_writer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                push,
  input  logic [DATA_WIDTH-1:0]               push_data,
  input  logic                                pop,
  output logic [DATA_WIDTH-1:0]               head,
  output logic [level_width(FIFO_DEPTH)-1:0]  level,
  output logic                                full,
  output logic                                empty
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = level_width(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Sample storage write port.
  // NOTE: the array has no reset; pointers and level alone define which
  // entries are valid, so the storage can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  // NOTE: non-blocking assignments make every flop here update from the
  // values present before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sample_burst_writer.sv
// AXI4 burst write master: buffers a valid/ready sample stream and writes
// each BURST_LEN samples as one INCR burst into a circular address region.
// Optional feature macro: SAMPLE_BURST_WRITER_ERR_CNT_EN (count non-OKAY
// write responses in err_cnt; otherwise err_cnt is tied to zero).
module sample_burst_writer
  import sample_burst_writer_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    BURST_LEN    = 8,
  parameter int                    FIFO_DEPTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    REGION_WORDS = 256
) (
  input  logic                               ACLK,
  input  logic                               ARESETN,
  input  logic                               enable,
  input  logic                               clr,
  input  logic                               s_valid,
  input  logic [DATA_WIDTH-1:0]              s_data,
  output logic                               s_ready,
  sample_burst_writer_if.master              m_axi,
  output logic [level_width(FIFO_DEPTH)-1:0] fifo_level,
  output logic                               overflow,
  output logic                               burst_done,
  output logic [15:0]                        err_cnt
);

  localparam int                    LW          = level_width(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * 4);
  localparam logic [ADDR_WIDTH-1:0] REGION_END  = BASE_ADDR + ADDR_WIDTH'(REGION_WORDS * 4);
  localparam logic [4:0]            LAST_BEAT   = 5'(BURST_LEN - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  wlast_q;
  logic                  bready_q;
  logic                  done_q;
  logic [4:0]            beat;
  logic                  fifo_full;
  logic                  fifo_empty_unused;
  logic [DATA_WIDTH-1:0] fifo_head;

  assign s_ready = !fifo_full;

  sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .push      (s_valid),
    .push_data (s_data),
    .pop       (wvalid_q && m_axi.wready),
    .head      (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty_unused)
  );

  // Pointer for the burst after the current one, folding back at region end.
  assign next_addr = (awaddr_q + BURST_BYTES == REGION_END) ? BASE_ADDR
                                                            : awaddr_q + BURST_BYTES;

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awlen   = 8'(BURST_LEN - 1);
  assign m_axi.awsize  = SIZE_4B;
  assign m_axi.awburst = BURST_INCR;
  assign m_axi.awid    = 1'b0;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = fifo_head;
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = wlast_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign burst_done    = done_q;

  // Burst sequencer: one AW, BURST_LEN W beats from the FIFO head, one B.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= IDLE;
      awaddr_q  <= BASE_ADDR;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b0;
      beat      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && fifo_level >= LW'(BURST_LEN)) begin
            awvalid_q <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (m_axi.awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wlast_q   <= (LAST_BEAT == 5'd0);
            beat      <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (m_axi.wready) begin
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state    <= RESP;
            end else begin
              beat    <= beat + 5'd1;
              wlast_q <= (beat + 5'd1 == LAST_BEAT);
            end
          end
        end
        RESP: begin
          if (m_axi.bvalid) begin
            bready_q <= 1'b0;
            done_q   <= 1'b1;
            awaddr_q <= next_addr;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overflow: a sample offered while full is dropped; clr wins.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                 overflow <= 1'b0;
    else if (clr)                 overflow <= 1'b0;
    else if (s_valid && !s_ready) overflow <= 1'b1;
  end

`ifdef SAMPLE_BURST_WRITER_ERR_CNT_EN
  // Saturating count of error responses; responses never affect flow control.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      err_cnt <= '0;
    end else if (clr) begin
      err_cnt <= '0;
    end else if (bready_q && m_axi.bvalid && m_axi.bresp != RESP_OKAY
                 && err_cnt != 16'hFFFF) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  logic bresp_unused;
  assign bresp_unused = ^m_axi.bresp;
  assign err_cnt      = '0;
`endif

endmodule

// File: doc/sample_burst_writer.md
# sample_burst_writer

AXI4 burst write master that sits directly upstream of the basicSampler AXI4 slave and feeds it. It buffers a valid/ready sample stream in an internal FIFO. Each time BURST_LEN samples are buffered, it writes them into the sampler's memory as one INCR burst. Successive bursts advance through a circular address region.

## Interface
Parameters:
- DATA_WIDTH, 32, sample and WDATA width (32 only; WSTRB all ones)
- ADDR_WIDTH, 32, AWADDR width
- BURST_LEN, 8, beats per burst (AWLEN = BURST_LEN-1), power of two, 1..16
- FIFO_DEPTH, 16, sample FIFO entries, power of two, ≥ BURST_LEN
- BASE_ADDR, 0, byte address of region start, aligned to BURST_LEN*4
- REGION_WORDS, 256, region size in words, multiple of BURST_LEN

Ports:
- ACLK  in  1  clock, all logic rising-edge
- ARESETN  in  1  asynchronous active-low reset
- enable  in  1  allows new bursts to start
- clr  in  1  clears overflow (and err_cnt)
- s_valid  in  1  sample valid
- s_data  in  DATA_WIDTH  sample
- s_ready  out  1  = !fifo_full
- m_axi_awaddr  out  ADDR_WIDTH; m_axi_awlen out 8; m_axi_awsize out 3 (=3'b010); m_axi_awburst out 2 (=INCR); m_axi_awid out 1 (=0)
- m_axi_awvalid out 1; m_axi_awready in 1
- m_axi_wdata out DATA_WIDTH; m_axi_wstrb out DATA_WIDTH/8; m_axi_wlast out 1; m_axi_wvalid out 1; m_axi_wready in 1
- m_axi_bresp in 2; m_axi_bvalid in 1; m_axi_bready out 1
- fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy
- overflow  out  1  sticky: sample offered while FIFO full
- burst_done  out  1  one-cycle pulse per completed burst
- err_cnt  out  16  non-OKAY BRESP count (see Configuration)

## Operation
- FIFO: first-word-fall-through. Push on s_valid && s_ready; pop on m_axi_wvalid && m_axi_wready. A simultaneous push and pop leaves the level unchanged. The FIFO is never written when full; the offered sample is dropped and overflow is set.
- FSM states IDLE, ADDR, DATA, RESP:
  - IDLE → ADDR when enable && fifo_level ≥ BURST_LEN. awaddr is already held at the current pointer.
  - ADDR: awvalid=1 until awready, then → DATA.
  - DATA: wvalid=1, wdata = FIFO head. The beat counter increments on each W handshake. wlast=1 on beat BURST_LEN-1. After the last handshake → RESP.
  - RESP: bready=1. On bvalid → IDLE, burst_done pulses, and the address pointer advances by BURST_LEN*4.
- Address wrap: when the advanced pointer equals BASE_ADDR + REGION_WORDS*4, it reloads BASE_ADDR.
- AW and W are strictly sequential; W never precedes AW acceptance. Only one burst is outstanding.
- Deasserting enable mid-burst does not abort: the burst completes, and no new burst starts.
- Outputs hold stable while valid is high and ready is low (AXI rule).
- overflow: set on s_valid && !s_ready. clr has priority over set in the same cycle.

## Timing
- Reset values: awvalid 0, wvalid 0, wlast 0, bready 0, awaddr BASE_ADDR, fifo_level 0, s_ready 1, overflow 0, burst_done 0, err_cnt 0. The FSM resets to IDLE.
- Reset mid-burst: immediately abandons the burst, empties the FIFO and reloads the pointer. No residual valid is asserted after release.
- awvalid rises the cycle after fifo_level reaches BURST_LEN (registered decision).
- wvalid rises the cycle after the AW handshake.
- bready rises the cycle after the wlast handshake.
- burst_done is registered: it fires the cycle after the B handshake.
- Minimum burst period with zero-wait slave: 1 + BURST_LEN + 1 + 1 cycles.
- fifo_level and s_ready reflect pushes/pops with one cycle of latency (registered).

## Configuration
- SAMPLE_BURST_WRITER_ERR_CNT_EN defined: err_cnt increments, saturating at 0xFFFF, on each B handshake with bresp ≠ OKAY. clr zeroes it.
- Not defined: err_cnt tied to 0; no counter logic is present. bresp is ignored in all cases for flow control.

## Structure
- Shared package sample_burst_writer_pkg: FSM state enum, AXI constants (INCR burst, size 3'b010, OKAY=2'b00), and the clog2-based level width function.
- One sub-module, sample_fifo (FWFT, parameterised DATA_WIDTH/FIFO_DEPTH, exposes level/full/empty). The FSM, address pointer and counters live in the top.

## Test plan
- Push 1..8, zero-wait slave, enable=1 → one AW at 0x0, awlen 7. wdata 1..8, wlast only on 8th. burst_done pulses once; next awaddr 0x20.
- Push 7 samples → no awvalid. The 8th sample then triggers the burst.
- REGION_WORDS=16, push 24 samples → awaddr sequence 0x00, 0x20, 0x00.
- awready delayed 5 cycles, wready toggled every cycle → awaddr/wdata stable while stalled. Data order 1..8 is preserved, and the AXI protocol checker is clean.
- FIFO_DEPTH=16, awready=0, push 20 samples → s_ready low after 16, overflow=1, fifo_level=16. clr → overflow 0.
- With macro defined, bresp=SLVERR on one burst → err_cnt=1. ARESETN pulse mid-DATA → all valids 0, fifo_level 0, awaddr BASE_ADDR.
